// File: rtl/game_controller.sv
// Round sequencer for the whack-a-mole game: IDLE -> COUNTDOWN -> PLAY -> OVER,
// tracking lives, remaining round ticks and the consecutive-hit streak.
module game_controller #(
  parameter int START_LIVES  = 3,
  parameter int ROUND_TICKS  = 60,
  parameter int COUNT_TICKS  = 3,
  parameter int STREAK_BONUS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tick,
  input  logic       hit_pulse,
  input  logic       miss_pulse,
  output logic       play_en,
  output logic       score_clr,
  output logic       game_over,
  output logic [2:0] lives,
  output logic [7:0] ticks_left,
  output logic [5:0] streak,
  output logic       bonus_pulse,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    COUNTDOWN = 2'b01,
    PLAY      = 2'b10,
    OVER      = 2'b11
  } state_t;

  localparam logic [2:0] LIVES_INIT  = 3'(START_LIVES);
  localparam logic [7:0] ROUND_INIT  = 8'(ROUND_TICKS);
  localparam logic [7:0] COUNT_INIT  = 8'(COUNT_TICKS);
  localparam logic [5:0] BONUS_LEVEL = 6'(STREAK_BONUS);

  state_t     state_q, state_d;
  logic [2:0] lives_d;
  logic [7:0] ticks_d;
  logic [5:0] streak_d;
  logic       score_clr_d;
  logic       bonus_d;

  function automatic logic [5:0] streak_inc(input logic [5:0] s);
    return (s == 6'd63) ? s : s + 6'd1;
  endfunction

  function automatic logic [7:0] ticks_dec(input logic [7:0] t);
    return (t == 8'd0) ? t : t - 8'd1;
  endfunction

  function automatic logic [2:0] lives_dec(input logic [2:0] l);
    return (l == 3'd0) ? l : l - 3'd1;
  endfunction

  always_comb begin
    logic [5:0] inc;
    state_d     = state_q;
    lives_d     = lives;
    ticks_d     = ticks_left;
    streak_d    = streak;
    score_clr_d = 1'b0;
    bonus_d     = 1'b0;
    inc         = streak_inc(streak);

    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d     = COUNTDOWN;
          ticks_d     = COUNT_INIT;
          lives_d     = LIVES_INIT;
          streak_d    = 6'd0;
          score_clr_d = 1'b1;
        end
      end
      COUNTDOWN: begin
        if (tick) begin
          if (ticks_left == 8'd1) begin
            state_d = PLAY;
            ticks_d = ROUND_INIT;
          end else begin
            ticks_d = ticks_dec(ticks_left);
          end
        end
      end
      PLAY: begin
        if (tick) begin
          ticks_d = ticks_dec(ticks_left);
          if (ticks_left <= 8'd1) state_d = OVER;
        end
        // A miss wins over a simultaneous hit: the hit is dropped entirely.
        if (miss_pulse) begin
          streak_d = 6'd0;
          lives_d  = lives_dec(lives);
          if (lives <= 3'd1) state_d = OVER;
        end else if (hit_pulse) begin
          if (inc == BONUS_LEVEL) begin
            bonus_d  = 1'b1;
            streak_d = 6'd0;
          end else begin
            streak_d = inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lives       <= LIVES_INIT;
      ticks_left  <= 8'd0;
      streak      <= 6'd0;
      play_en     <= 1'b0;
      score_clr   <= 1'b0;
      game_over   <= 1'b0;
      bonus_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives       <= lives_d;
      ticks_left  <= ticks_d;
      streak      <= streak_d;
      play_en     <= (state_d == PLAY);
      score_clr   <= score_clr_d;
      game_over   <= (state_d == OVER);
      bonus_pulse <= bonus_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed-vector bench for game_controller with hand-computed expectations.
module tb_game_controller;

  logic       clk = 1'b0;
  logic       rst, start, tick, hit_pulse, miss_pulse;
  logic       play_en, score_clr, game_over, bonus_pulse;
  logic [2:0] lives;
  logic [7:0] ticks_left;
  logic [5:0] streak;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  game_controller #(
    .START_LIVES(3), .ROUND_TICKS(60), .COUNT_TICKS(3), .STREAK_BONUS(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .play_en(play_en), .score_clr(score_clr), .game_over(game_over),
    .lives(lives), .ticks_left(ticks_left), .streak(streak),
    .bonus_pulse(bonus_pulse), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1ns after the capturing edge.
  task automatic drive(input logic s, input logic t, input logic h, input logic m);
    start = s; tick = t; hit_pulse = h; miss_pulse = m;
    @(posedge clk);
    #1;
    start = 1'b0; tick = 1'b0; hit_pulse = 1'b0; miss_pulse = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; tick = 1'b0; hit_pulse = 1'b0; miss_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_lives", lives, 3);
    chk("rst_ticks", ticks_left, 0);
    chk("rst_streak", streak, 0);
    chk("rst_play_en", play_en, 0);
    chk("rst_score_clr", score_clr, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_bonus", bonus_pulse, 0);
    @(negedge clk);
    rst = 1'b1;

    // IDLE ignores tick/hit/miss
    drive(0, 1, 1, 1);
    chk("idle_state", state, 0);
    chk("idle_lives", lives, 3);
    chk("idle_streak", streak, 0);

    drive(1, 0, 0, 0);
    chk("start_clr", score_clr, 1);
    chk("start_state", state, 1);
    chk("start_ticks", ticks_left, 3);
    drive(0, 0, 1, 1);
    chk("clr_drop", score_clr, 0);
    chk("cd_ignore_lives", lives, 3);
    chk("cd_ignore_streak", streak, 0);
    drive(0, 1, 0, 0);
    chk("cd_t1", ticks_left, 2);
    drive(1, 1, 0, 0);
    chk("cd_t2", ticks_left, 1);
    chk("cd_start_ignored", score_clr, 0);
    drive(0, 1, 0, 0);
    chk("play_state", state, 2);
    chk("play_en", play_en, 1);
    chk("play_ticks", ticks_left, 60);

    // Streak and bonus
    for (int i = 1; i <= 4; i++) drive(0, 0, 1, 0);
    chk("streak4", streak, 4);
    chk("no_bonus_yet", bonus_pulse, 0);
    drive(0, 0, 1, 0);
    chk("bonus_fire", bonus_pulse, 1);
    chk("bonus_streak0", streak, 0);
    drive(0, 0, 0, 0);
    chk("bonus_single", bonus_pulse, 0);
    drive(0, 0, 1, 0);
    chk("streak_after_bonus", streak, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0);
    chk("streak_back4", streak, 4);

    // Hit and miss together: miss wins, no bonus
    drive(0, 0, 1, 1);
    chk("hm_lives", lives, 2);
    chk("hm_streak", streak, 0);
    chk("hm_bonus", bonus_pulse, 0);
    drive(1, 0, 0, 1);
    chk("miss2_lives", lives, 1);
    chk("play_start_ignored", state, 2);
    drive(0, 0, 0, 1);
    chk("miss3_lives", lives, 0);
    chk("over_state", state, 3);
    chk("over_game_over", game_over, 1);
    chk("over_play_en", play_en, 0);
    chk("over_ticks_hold", ticks_left, 60);
    drive(0, 1, 0, 1);
    chk("over_hold_ticks", ticks_left, 60);
    chk("over_hold_lives", lives, 0);

    // Restart from OVER, then full-length round
    drive(1, 0, 0, 0);
    chk("restart_clr", score_clr, 1);
    chk("restart_state", state, 1);
    chk("restart_lives", lives, 3);
    chk("restart_go_clear", game_over, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
    chk("play2_state", state, 2);
    for (int i = 0; i < 59; i++) drive(0, 1, 0, 0);
    chk("t59_ticks", ticks_left, 1);
    chk("t59_state", state, 2);
    drive(0, 1, 1, 0);
    chk("t60_ticks", ticks_left, 0);
    chk("t60_state", state, 3);
    chk("t60_lives", lives, 3);
    chk("t60_hit_counted", streak, 1);
    drive(1, 0, 0, 0);
    chk("restart2_clr", score_clr, 1);
    chk("restart2_state", state, 1);
    chk("restart2_lives", lives, 3);

    // Last tick together with the final miss
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 59; i++) drive(0, 1, 0, 0);
    drive(0, 1, 0, 1);
    chk("tm_lives", lives, 0);
    chk("tm_ticks", ticks_left, 0);
    chk("tm_state", state, 3);

    // Asynchronous reset mid-PLAY
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
    drive(0, 0, 1, 1);
    chk("pre_rst_state", state, 2);
    #1 rst = 1'b0;
    #1;
    chk("async_play_en", play_en, 0);
    chk("async_state", state, 0);
    chk("async_lives", lives, 3);
    chk("async_clr", score_clr, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("post_rst_state", state, 0);
    chk("post_rst_ticks", ticks_left, 0);
    chk("post_rst_clr", score_clr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Round-level FSM sitting directly downstream of mole_detector and score_updater's pulse sources.
- Consumes hit_pulse/miss_pulse plus the LED_toggle mole tick.
- Sequences IDLE -> COUNTDOWN -> PLAY -> OVER, tracks lives, round time and hit streak.
- Outputs gating signals: play_en gates activate_LED/mole_detector; score_clr clears score_updater at round start.

Parameters:
- START_LIVES, 3, lives loaded at round start (1..7).
- ROUND_TICKS, 60, mole ticks per round (1..255).
- COUNT_TICKS, 3, countdown length in mole ticks (1..7).
- STREAK_BONUS, 5, consecutive hits that produce one bonus_pulse (1..63).

Ports:
- clk  input  1  system clock (CLOCK_50).
- rst  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse (debounced key press edge).
- tick  input  1  single-cycle mole tick (LED_toggle).
- hit_pulse  input  1  single-cycle hit from mole_detector.
- miss_pulse  input  1  single-cycle miss from mole_detector.
- play_en  output  1  high only in PLAY.
- score_clr  output  1  single-cycle pulse on IDLE/OVER -> COUNTDOWN.
- game_over  output  1  high in OVER.
- lives  output  3  remaining lives.
- ticks_left  output  8  remaining round ticks; countdown value during COUNTDOWN.
- streak  output  6  current consecutive-hit count.
- bonus_pulse  output  1  single-cycle pulse each time streak reaches STREAK_BONUS.
- state  output  2  IDLE=00, COUNTDOWN=01, PLAY=10, OVER=11 (debug / display select).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; lives=START_LIVES; ticks_left=0; streak=0; play_en=0; score_clr=0; game_over=0; bonus_pulse=0.
- All outputs registered; every transition takes effect one clk after the causing input.
- IDLE: on start, go to COUNTDOWN and load:
  - ticks_left=COUNT_TICKS
  - lives=START_LIVES
  - streak=0
  - score_clr=1 for exactly that cycle.
  - hit/miss/tick are ignored.
- COUNTDOWN: each tick decrements ticks_left.
  - On the tick where ticks_left==1: go to PLAY, load ticks_left=ROUND_TICKS.
  - hit/miss are ignored. start is ignored.
- PLAY: play_en=1.
  - tick: ticks_left decrements. On the tick where ticks_left==1, go to OVER with ticks_left=0.
  - hit_pulse: streak increments, saturating at 63.
    - When the incremented value equals STREAK_BONUS, bonus_pulse=1 for one cycle and streak resets to 0.
  - miss_pulse: streak=0, lives decrements.
    - If lives was 1, go to OVER with lives=0.
  - start is ignored.
- OVER: game_over=1, play_en=0; lives, ticks_left and streak hold.
  - On start: restart exactly as from IDLE, including the score_clr pulse.
- Simultaneous events in PLAY, same cycle:
  - hit and miss together: the miss is applied (lives decrement, streak=0), the hit is dropped, no bonus.
  - Last-tick expiry together with a miss: both applied; lives decrement, go to OVER.
  - hit together with last tick: hit counted, bonus may fire, then OVER.
- Arithmetic: lives and ticks_left never underflow below 0; streak never exceeds 63.
- Reset mid-round: immediate return to IDLE values and play_en=0 asynchronously; no score_clr pulse is issued on reset.

Test Plan:
- Reset then start -> score_clr high for 1 cycle; state=01, ticks_left=3. After 3 ticks -> state=10, play_en=1, ticks_left=60.
- In PLAY, 5 hit_pulses -> bonus_pulse exactly once on the cycle after the 5th hit; streak=0. A 6th hit -> streak=1.
- In PLAY, 3 miss_pulses -> lives 3->2->1->0. On the cycle after the 3rd miss: state=11, game_over=1, play_en=0.
- In PLAY, hit and miss in the same cycle with lives=3, streak=4 -> lives=2, streak=0, no bonus_pulse.
- 60 ticks in PLAY with no misses -> after the 60th tick: ticks_left=0, state=11, lives=3. Then start -> score_clr pulse, state=01, lives=3.
- Drive rst=0 mid-PLAY between clock edges -> play_en and state drop to 0 without waiting for clk; ticks ignored until the next start.
